// File: rtl/seqdiv_pkg.sv
// seqdiv_pkg: shared types and constants for the sequential 8086 DIV/IDIV divider.
//   divState_t   : controller states (LOAD is the IDLE->CALC/FIX edge, not a state)
//   width params : operand, result and counter widths
//   condNeg*     : conditional two's complement helpers used for sign/magnitude work
package seqdiv_pkg;

  // Controller states; 2-bit encoding shared with the other ALU datapath blocks
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } divState_t;

  // Output layout: word {rem[15:0],quot[15:0]}, byte {16'd0,rem[7:0],quot[7:0]}
  localparam int OUT_W   = 32;
  localparam int DVD_W   = 32;
  localparam int DIV_W   = 16;
  localparam int HALF_W  = 16;
  localparam int PREM_W  = 17;
  localparam int CNT_W   = 5;

  // Number of quotient bits produced for each operand size
  localparam logic [CNT_W-1:0] WORD_STEPS = 5'd16;
  localparam logic [CNT_W-1:0] BYTE_STEPS = 5'd8;

  // Two's complement negate when neg is set, pass through otherwise.
  // Negating zero yields zero, so no -0 special case is needed anywhere.
  function automatic logic [31:0] condNeg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [15:0] condNeg16(input logic [15:0] v, input logic neg);
    return neg ? (~v + 16'd1) : v;
  endfunction

  function automatic logic [7:0] condNeg8(input logic [7:0] v, input logic neg);
    return neg ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/seqdiv_step.sv
// seqdiv_step: one restoring-division iteration, purely combinational.
//   i_rem     : held partial remainder (always below the divisor, so 16 bits)
//   i_lo      : remaining dividend bits, MSB is the next bit brought down
//   i_div     : divisor magnitude
//   o_rem     : partial remainder after the trial subtract (restored if negative)
//   o_shifted : i_lo shifted left by one, quotient bit not yet appended
//   o_qbit    : quotient bit produced by this iteration
module seqdiv_step
  import seqdiv_pkg::*;
(
  input  logic [HALF_W-1:0] i_rem,
  input  logic [HALF_W-1:0] i_lo,
  input  logic [DIV_W-1:0]  i_div,
  output logic [HALF_W-1:0] o_rem,
  output logic [HALF_W-2:0] o_shifted,
  output logic              o_qbit
);

  logic [PREM_W-1:0] w_part;
  logic [PREM_W-1:0] w_diff;
  logic              w_unusedDiffMsb;

  // Shift {rem,dvd} left by one: the partial remainder grows to N+1 bits here,
  // which is why the trial compare is done at 17 bits.
  always_comb begin
    w_part    = {i_rem, i_lo[HALF_W-1]};
    w_diff    = w_part - {1'b0, i_div};
    o_qbit    = (w_part >= {1'b0, i_div});
    o_rem     = o_qbit ? w_diff[HALF_W-1:0] : w_part[HALF_W-1:0];
    o_shifted = i_lo[HALF_W-2:0];
  end

  // The kept difference is below the divisor, so its top bit is always zero
  assign w_unusedDiffMsb = w_diff[PREM_W-1];

endmodule

// File: rtl/seqdiv.sv
// seqdiv: multi-cycle restoring divider for 8086 DIV/IDIV (word 32/16, byte 16/8).
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle request, accepted only when idle and not in the done cycle
//   x, y       : dividend (DX:AX or AX) and divisor (16 or low 8 bits)
//   word_op    : 1 = 16-bit operation, 0 = 8-bit operation
//   signed_op  : 1 = IDIV, 0 = DIV
//   out        : word {rem,quot}; byte {16'd0,rem8,quot8}; held when exc is raised
//   busy       : from the cycle after an accepted start through the done cycle
//   done       : one-cycle completion pulse, out/exc valid with it
//   exc        : divide error (type-0 interrupt request), valid with done
module seqdiv
  import seqdiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] x,
  input  logic [DIV_W-1:0] y,
  input  logic             word_op,
  input  logic             signed_op,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             exc
);

  divState_t r_state;
  divState_t w_nextState;
  logic      w_accept;

  // Operand and iteration registers
  logic [HALF_W-1:0] r_rem;
  logic [HALF_W-1:0] r_lo;
  logic [DIV_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_count;
  logic              r_qneg;
  logic              r_rneg;
  logic              r_word;
  logic              r_signed;
  logic              r_err;

  // Output registers
  logic [OUT_W-1:0]  r_out;
  logic              r_done;
  logic              r_exc;

  // Load-time magnitudes and early error detection
  logic              w_sx;
  logic              w_sy;
  logic [DVD_W-1:0]  w_dvdMag;
  logic [DIV_W-1:0]  w_divMag;
  logic              w_loadErr;
  logic [HALF_W-1:0] w_loadRem;
  logic [HALF_W-1:0] w_loadLo;

  // Iteration step outputs
  logic [HALF_W-1:0] w_stepRem;
  logic [HALF_W-2:0] w_stepShifted;
  logic              w_stepQbit;

  // Final fixup
  logic [HALF_W-1:0] w_qMag;
  logic [HALF_W-1:0] w_rMag;
  logic [HALF_W-1:0] w_quot;
  logic [HALF_W-1:0] w_remSigned;
  logic              w_rangeErr;
  logic              w_fixErr;
  logic [OUT_W-1:0]  w_result;

  // Sign extraction and magnitude conversion of the incoming operands.
  // Byte mode ignores x[31:16] and y[15:8]; the byte dividend is left-aligned
  // in r_lo so the same 16-bit shifter brings its bits down MSB first.
  always_comb begin
    w_sx      = signed_op & (word_op ? x[31] : x[15]);
    w_sy      = signed_op & (word_op ? y[15] : y[7]);
    w_dvdMag  = word_op ? condNeg32(x, w_sx) : {16'd0, condNeg16(x[15:0], w_sx)};
    w_divMag  = word_op ? condNeg16(y, w_sy) : {8'd0, condNeg8(y[7:0], w_sy)};
    w_loadErr = (w_divMag == '0) |
                (word_op ? (w_dvdMag[31:16] >= w_divMag)
                         : ({8'd0, w_dvdMag[15:8]} >= w_divMag));
    w_loadRem = word_op ? w_dvdMag[31:16] : {8'd0, w_dvdMag[15:8]};
    w_loadLo  = word_op ? w_dvdMag[15:0]  : {w_dvdMag[7:0], 8'd0};
  end

  seqdiv_step u_step (
    .i_rem     (r_rem),
    .i_lo      (r_lo),
    .i_div     (r_div),
    .o_rem     (w_stepRem),
    .o_shifted (w_stepShifted),
    .o_qbit    (w_stepQbit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A start arriving while r_done is high lands in IDLE
  // but must still be dropped, since the done cycle counts as busy.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_done) begin
          w_accept    = 1'b1;
          w_nextState = w_loadErr ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_count == 5'd1) begin
          w_nextState = ST_FIX;
        end
      end
      ST_FIX: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // LOAD on the accepting edge, then one quotient bit per CALC cycle.
  // Quotient bits are shifted into the bottom of r_lo as dividend bits leave the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_lo     <= '0;
      r_div    <= '0;
      r_count  <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_word   <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_rem    <= w_loadRem;
      r_lo     <= w_loadLo;
      r_div    <= w_divMag;
      r_count  <= word_op ? WORD_STEPS : BYTE_STEPS;
      r_qneg   <= w_sx ^ w_sy;
      r_rneg   <= w_sx;
      r_word   <= word_op;
      r_signed <= signed_op;
      r_err    <= w_loadErr;
    end else if (r_state == ST_CALC) begin
      r_rem    <= w_stepRem;
      r_lo     <= {w_stepShifted, w_stepQbit};
      r_count  <= r_count - 5'd1;
    end
  end

  // Fixup: apply signs and the IDIV range rule. A quotient magnitude with the
  // top bit set cannot be represented once signed (8086 also rejects -2^(N-1)).
  always_comb begin
    w_qMag      = r_word ? r_lo  : {8'd0, r_lo[7:0]};
    w_rMag      = r_word ? r_rem : {8'd0, r_rem[7:0]};
    w_rangeErr  = r_signed & (r_word ? w_qMag[15] : w_qMag[7]);
    w_fixErr    = r_err | w_rangeErr;
    w_quot      = condNeg16(w_qMag, r_qneg);
    w_remSigned = condNeg16(w_rMag, r_rneg);
    w_result    = r_word ? {w_remSigned, w_quot}
                         : {16'd0, w_remSigned[7:0], w_quot[7:0]};
  end

  // done/exc are registered out of FIX, so the pulse lands one cycle after FIX;
  // out is only written on a successful result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_done <= 1'b0;
      r_exc  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      r_exc  <= (r_state == ST_FIX) & w_fixErr;
      if ((r_state == ST_FIX) && !w_fixErr) begin
        r_out <= w_result;
      end
    end
  end

  assign out  = r_out;
  assign done = r_done;
  assign exc  = r_exc;
  assign busy = (r_state != ST_IDLE) | r_done;

endmodule

// File: tb/tb_seqdiv.sv
// tb_seqdiv: directed self-checking bench for seqdiv with hand-computed results.
// Cycle 0 is the cycle in which start is held high; outputs are sampled on the
// falling edge so each sample shows the state of the current cycle.
module tb_seqdiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [15:0] y;
  logic        word_op;
  logic        signed_op;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        exc;

  int compareCount  = 0;
  int mismatchCount = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  seqdiv dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .word_op   (word_op),
    .signed_op (signed_op),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .exc       (exc)
  );

  // Single comparison point: counts and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present one request on the falling edge; it is sampled at the next rising edge
  task automatic applyStimulus(input logic [31:0] vx, input logic [15:0] vy,
                               input logic vword, input logic vsigned);
    @(negedge clk);
    x         = vx;
    y         = vy;
    word_op   = vword;
    signed_op = vsigned;
    start     = 1'b1;
  endtask

  // Run one divide over a fixed 22-cycle window, optionally re-pulsing start
  // or asserting reset at given cycles, then check timing and results.
  task automatic runDivide(input string tag, input logic [31:0] vx, input logic [15:0] vy,
                           input logic vword, input logic vsigned, input int expCycle,
                           input logic [31:0] expOut, input logic expExc,
                           input int pulseA, input int pulseB, input int rstCyc);
    int          firstDone;
    int          doneCount;
    int          busyGaps;
    logic [31:0] gotOut;
    logic        gotExc;
    logic        busyAfter;
    logic        excAfter;
    logic        doneAfter;
    logic        busyRst;
    logic [31:0] outRst;
    firstDone = -1;
    doneCount = 0;
    busyGaps  = 0;
    gotOut    = '0;
    gotExc    = 1'b0;
    busyAfter = 1'b1;
    excAfter  = 1'b1;
    doneAfter = 1'b1;
    busyRst   = 1'b1;
    outRst    = '1;
    applyStimulus(vx, vy, vword, vsigned);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (firstDone < 0 && rstCyc < 0 && !busy) busyGaps++;
      if (done) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = c;
          gotOut    = out;
          gotExc    = exc;
        end
      end
      if (firstDone >= 0 && c == firstDone + 1) begin
        busyAfter = busy;
        excAfter  = exc;
        doneAfter = done;
      end
      if (c == rstCyc + 1) begin
        busyRst = busy;
        outRst  = out;
      end
      start = (c == pulseA) || (c == pulseB);
      rst   = (c == rstCyc);
    end
    start = 1'b0;
    rst   = 1'b0;
    checkOutput({tag, ".doneCycle"}, 32'(firstDone), 32'(expCycle));
    checkOutput({tag, ".doneCount"}, 32'(doneCount), (expCycle < 0) ? 32'd0 : 32'd1);
    if (rstCyc < 0) begin
      checkOutput({tag, ".out"}, gotOut, expOut);
      checkOutput({tag, ".exc"}, {31'd0, gotExc}, {31'd0, expExc});
      checkOutput({tag, ".busyGaps"}, 32'(busyGaps), 32'd0);
      checkOutput({tag, ".busyAfter"}, {31'd0, busyAfter}, 32'd0);
      checkOutput({tag, ".excAfter"}, {31'd0, excAfter}, 32'd0);
      checkOutput({tag, ".doneAfter"}, {31'd0, doneAfter}, 32'd0);
    end else begin
      checkOutput({tag, ".busyAfterRst"}, {31'd0, busyRst}, 32'd0);
      checkOutput({tag, ".outAfterRst"}, outRst, 32'd0);
    end
  endtask

  // Directed sequence; each error vector expects out to keep the last good result
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    x         = '0;
    y         = '0;
    word_op   = 1'b0;
    signed_op = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.out",  out, 32'd0);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    checkOutput("reset.exc",  {31'd0, exc},  32'd0);
    rst = 1'b0;

    runDivide("divWord",    32'h0001_0000, 16'h0003, 1'b1, 1'b0, 18, 32'h0001_5555, 1'b0, -1, -1, -1);
    runDivide("divByte",    32'h0000_00FF, 16'h0010, 1'b0, 1'b0, 10, 32'h0000_0F0F, 1'b0, -1, -1, -1);
    runDivide("divZero",    32'h0000_1234, 16'h0000, 1'b1, 1'b0,  2, 32'h0000_0F0F, 1'b1, -1, -1, -1);
    runDivide("idivWord",   32'hFFFF_FFF9, 16'h0002, 1'b1, 1'b1, 18, 32'hFFFF_FFFD, 1'b0, -1, -1, -1);
    runDivide("divOvf",     32'h0003_0000, 16'h0003, 1'b1, 1'b0,  2, 32'hFFFF_FFFD, 1'b1, -1, -1, -1);
    runDivide("idivWMin",   32'hFFFF_8000, 16'h0001, 1'b1, 1'b1, 18, 32'hFFFF_FFFD, 1'b1, -1, -1, -1);
    runDivide("idivBMin",   32'h0000_FF80, 16'h0001, 1'b0, 1'b1, 10, 32'hFFFF_FFFD, 1'b1, -1, -1, -1);
    runDivide("idivByte",   32'hABCD_FF9C, 16'h1207, 1'b0, 1'b1, 10, 32'h0000_FEF2, 1'b0, -1, -1, -1);
    runDivide("idivNegDiv", 32'h0000_0064, 16'hFFF9, 1'b1, 1'b1, 18, 32'h0002_FFF2, 1'b0, -1, -1, -1);
    runDivide("restart",    32'h0000_FFFF, 16'h00FF, 1'b1, 1'b0, 18, 32'h0000_0101, 1'b0,  3, 18, -1);
    runDivide("midReset",   32'h0001_0000, 16'h0003, 1'b1, 1'b0, -1, 32'h0000_0000, 1'b0, -1, -1,  7);
    runDivide("afterRst",   32'h0000_0064, 16'h000A, 1'b0, 1'b0, 10, 32'h0000_000A, 1'b0, -1, -1, -1);
    runDivide("idivBMax",   32'h0000_FF81, 16'h0001, 1'b0, 1'b1, 10, 32'h0000_0081, 1'b0, -1, -1, -1);
    runDivide("divBOvf",    32'h0000_0100, 16'h0001, 1'b0, 1'b0,  2, 32'h0000_0081, 1'b1, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
